// File: rtl/ppu_issue_ctrl.sv
// PPU issue controller: latches one instruction, pulses all lanes, gathers per-lane results.
// Optional watchdog enabled by defining PPU_TIMEOUT_EN.
`ifndef PPU_OP_WIDTH
`define PPU_OP_WIDTH 6
`endif

module ppu_issue_ctrl #(
  parameter int PPU_NUM        = 1,
  parameter int OP_W           = `PPU_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic [31:0]        op_a_i,
  input  logic [31:0]        op_b_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               kill_i,
  output logic               ppu_valid_in_o,
  output logic [31:0]        ppu_in1_o,
  output logic [31:0]        ppu_in2_o,
  output logic [OP_W-1:0]    ppu_op_o,
  input  logic [PPU_NUM-1:0] ppu_valid_i,
  input  logic [31:0]        ppu_out_i,
  output logic [31:0]        result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam int LW = 32 / PPU_NUM;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         state, state_nx;
  logic [PPU_NUM-1:0] done_q, done_nx, cap;
  logic [31:0]        acc_q, acc_nx, res_q;
  logic [31:0]        in1_q, in2_q;
  logic [OP_W-1:0]    op_q;
  logic               collecting, all_done, start, go_done, to_hit;

  assign collecting = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
  assign cap        = collecting ? (ppu_valid_i & ~done_q) : '0;
  assign done_nx    = done_q | cap;
  assign all_done   = &done_nx;
  assign start      = (state == S_IDLE) && req_valid_i && !kill_i;

  // first valid per lane wins; repeats on a finished lane leave its slice untouched
  genvar gi;
  generate
    for (gi = 0; gi < PPU_NUM; gi++) begin : g_lane
      assign acc_nx[LW*gi +: LW] = cap[gi] ? ppu_out_i[LW*gi +: LW] : acc_q[LW*gi +: LW];
    end
  endgenerate

`ifdef PPU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic          err_q;

  assign cnt_inc = cnt_q + 1'b1;
  assign to_hit  = ((state == S_WAIT) || (state == S_DRAIN)) && (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        cnt_q <= '0;
      else if ((state == S_WAIT) || (state == S_DRAIN))
        cnt_q <= cnt_inc;
      err_q <= go_done && !all_done;
    end
  end
  assign err_o = err_q;
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE, S_WAIT: begin
        // a kill that lands with the last lane has nothing left to drain
        if (all_done)    state_nx = kill_i ? S_IDLE : S_DONE;
        else if (kill_i) state_nx = S_DRAIN;
        else if (to_hit) state_nx = S_DONE;
        else             state_nx = S_WAIT;
      end
      S_DONE:  state_nx = S_IDLE;
      S_DRAIN: if (all_done || to_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign go_done = ((state == S_ISSUE) || (state == S_WAIT)) && (state_nx == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      done_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      op_q   <= '0;
    end else begin
      state <= state_nx;
      acc_q <= acc_nx;
      if (start) begin
        done_q <= '0;
        in1_q  <= op_a_i;
        in2_q  <= op_b_i;
        op_q   <= op_i;
      end else begin
        done_q <= done_nx;
      end
      // result_o only moves on entry to DONE; a watchdog expiry reports zero
      if (go_done)
        res_q <= all_done ? acc_nx : 32'h0;
    end
  end

  assign ppu_valid_in_o = (state == S_ISSUE);
  assign ready_o        = (state == S_DONE);
  assign busy_o         = (state != S_IDLE);
  assign result_o       = res_q;
  assign ppu_in1_o      = in1_q;
  assign ppu_in2_o      = in2_q;
  assign ppu_op_o       = op_q;

endmodule
